uart_fifo_bridge: RTL and testbench

- Buffers both directions of the Z80 serial port.
- Sits between the UART primitives (async_receiver, async_transmitter) and the CPU-facing register decode in the system module.
- RX side: captures every byte pulsed out by the receiver into a FIFO. The CPU pops bytes at its own pace.
- TX side: the CPU pushes bytes without polling the transmitter's busy flag. A drain FSM feeds the transmitter via its start/busy handshake.

---
 rtl/uart_fifo_bridge.sv | 169 ++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs for both directions of the Z80 serial port, plus a drain FSM that
// feeds queued TX bytes to the transmitter one start/busy handshake at a time.
module uart_fifo_bridge #(
   parameter int RX_AW       = 4,
   parameter int TX_AW       = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_pop,
   output logic [7:0]       rx_dout,
   output logic             rx_empty,
   output logic [RX_AW:0]   rx_count,
   output logic             rx_overflow,
   input  logic             tx_push,
   input  logic [7:0]       tx_din,
   output logic             tx_full,
   output logic [TX_AW:0]   tx_count,
   output logic             tx_overflow,
   output logic             tx_timeout,
   input  logic             clr_flags,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic             tx_busy,
   output logic [1:0]       fsm_state
);
   localparam int RX_DEPTH = 1 << RX_AW;
   localparam int TX_DEPTH = 1 << TX_AW;
   localparam int TW       = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_ACK   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t state, state_next;

   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic             rx_full, rx_do_pop, rx_do_push, rx_ovf_set;

   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic             tx_empty, tx_pop, tx_do_push, tx_ovf_set;

   logic [TW-1:0]    ack_cnt;
   logic             ack_last, cnt_clr, cnt_inc, to_set;

   // ---------------- RX FIFO ----------------
   assign rx_empty   = (rx_count == '0);
   assign rx_full    = (rx_count == (RX_AW+1)'(RX_DEPTH));
   assign rx_dout    = rx_mem[rx_rd_ptr];
   assign rx_do_pop  = rx_pop && !rx_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign rx_do_push = rx_valid && (!rx_full || rx_do_pop);
   assign rx_ovf_set = rx_valid && !rx_do_push;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= 8'h00;
         rx_wr_ptr   <= '0;
         rx_rd_ptr   <= '0;
         rx_count    <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_do_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
            rx_wr_ptr         <= rx_wr_ptr + RX_AW'(1);
         end
         if (rx_do_pop) rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         case ({rx_do_push, rx_do_pop})
            2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
            2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
            default: rx_count <= rx_count;
         endcase
         rx_overflow <= rx_ovf_set || (rx_overflow && !clr_flags);
      end
   end

   // ---------------- TX FIFO ----------------
   assign tx_empty   = (tx_count == '0);
   assign tx_full    = (tx_count == (TX_AW+1)'(TX_DEPTH));
   assign tx_do_push = tx_push && (!tx_full || tx_pop);
   assign tx_ovf_set = tx_push && !tx_do_push;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= 8'h00;
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_count    <= '0;
         tx_overflow <= 1'b0;
      end else begin
         if (tx_do_push) begin
            tx_mem[tx_wr_ptr] <= tx_din;
            tx_wr_ptr         <= tx_wr_ptr + TX_AW'(1);
         end
         if (tx_pop) tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
         case ({tx_do_push, tx_pop})
            2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
            2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
            default: tx_count <= tx_count;
         endcase
         tx_overflow <= tx_ovf_set || (tx_overflow && !clr_flags);
      end
   end

   // ---------------- Drain FSM ----------------
   // Handshake: tx_start is a one-cycle request carrying tx_data; the transmitter
   // acknowledges by raising tx_busy, and the byte is done when tx_busy falls.
   assign ack_last  = (ack_cnt == TW'(ACK_TIMEOUT - 1));
   assign fsm_state = state;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (!tx_empty && !tx_busy) state_next = S_START;
         S_START: state_next = S_ACK;
         S_ACK: begin
            if (tx_busy)       state_next = S_DRAIN;
            else if (ack_last) state_next = S_IDLE;
         end
         S_DRAIN: if (!tx_busy) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      tx_pop  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      to_set  = 1'b0;
      case (state)
         S_IDLE:  tx_pop  = !tx_empty && !tx_busy;
         S_START: cnt_clr = 1'b1;
         S_ACK: begin
            if (!tx_busy) begin
               if (ack_last) to_set  = 1'b1;
               else          cnt_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         tx_data    <= 8'h00;
         tx_start   <= 1'b0;
         ack_cnt    <= '0;
         tx_timeout <= 1'b0;
      end else begin
         if (tx_pop) tx_data <= tx_mem[tx_rd_ptr];
         tx_start <= (state_next == S_START);
         if (cnt_clr)      ack_cnt <= '0;
         else if (cnt_inc) ack_cnt <= ack_cnt + TW'(1);
         tx_timeout <= to_set || (tx_timeout && !clr_flags);
      end
   end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: RX vector table, hand-written TX/timeout/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_uart_fifo_bridge;
   localparam int         ACK_TIMEOUT = 15;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACK   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic       rx_valid = 1'b0, rx_pop = 1'b0, tx_push = 1'b0, clr_flags = 1'b0;
   logic [7:0] rx_data = 8'h00, tx_din = 8'h00;
   logic       tx_busy = 1'b0;
   logic [7:0] rx_dout, tx_data;
   logic [4:0] rx_count, tx_count;
   logic       rx_empty, rx_overflow, tx_full, tx_overflow, tx_timeout, tx_start;
   logic [1:0] fsm_state;

   uart_fifo_bridge #(.RX_AW(4), .TX_AW(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
      .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_count(rx_count), .rx_overflow(rx_overflow),
      .tx_push(tx_push), .tx_din(tx_din), .tx_full(tx_full), .tx_count(tx_count),
      .tx_overflow(tx_overflow), .tx_timeout(tx_timeout), .clr_flags(clr_flags),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle_inputs();
      rx_valid = 1'b0; rx_pop = 1'b0; tx_push = 1'b0; clr_flags = 1'b0;
   endtask

   // ---------------- transmitter model ----------------
   int         xm_len   = 100;
   bit         xm_dead  = 1'b0;
   int         xm_delay = 0;
   int         xm_left  = 0;
   int         n_starts = 0;
   logic [7:0] sent_q[$];

   always @(negedge clk_sys) begin
      if (xm_left > 0) begin
         xm_left = xm_left - 1;
         if (xm_left == 0) tx_busy = 1'b0;
      end else if (xm_delay > 0) begin
         xm_delay = xm_delay - 1;
         if (xm_delay == 0) begin
            tx_busy = 1'b1;
            xm_left = xm_len;
         end
      end
      if (tx_start === 1'b1) begin
         n_starts++;
         sent_q.push_back(tx_data);
         check("start_while_busy", tx_busy, 0);
         if (!xm_dead) xm_delay = 1;
      end
   end

   // ---------------- RX vector table ----------------
   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       p;
      logic       c;
      logic [7:0] exp_head;
      logic [4:0] exp_cnt;
      logic       exp_empty;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic p, input logic c,
                               input logic [7:0] h, input int cnt, input logic e, input logic o);
      vec_t r;
      r.v = v; r.d = d; r.p = p; r.c = c; r.exp_head = h;
      r.exp_cnt = 5'(cnt); r.exp_empty = e; r.exp_ovf = o;
      return r;
   endfunction

   // ---------------- scoreboard for random phase ----------------
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   bit         m_rx_ovf = 1'b0;
   bit         m_tx_ovf = 1'b0;

   initial begin
      int s0, k0;
      logic rv, rp, tp, cf, popped, rx_pe, rx_ok, tx_ok;
      logic [7:0] rd, td;
      int tsz;

      // reset state
      #2;
      check("rst_rx_empty", rx_empty, 1);
      check("rst_rx_count", rx_count, 0);
      check("rst_tx_full", tx_full, 0);
      check("rst_tx_count", tx_count, 0);
      check("rst_flags", {rx_overflow, tx_overflow, tx_timeout}, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_rx_dout", rx_dout, 8'h00);
      check("rst_fsm", fsm_state, ST_IDLE);
      #10 reset = 1'b0;
      tick();

      // RX fill / overflow, then drain in order
      for (int i = 0; i < 17; i++) vecs.push_back(mk(1, 8'(i), 0, 0, 0, (i < 16) ? i + 1 : 16, 0, i == 16));
      for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 0, 1, 0, 8'(i), 15 - i, i == 15, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
      // RX simultaneous push/pop while full
      for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 8'(8'h40 + i), 0, 0, 0, i + 1, 0, 0));
      vecs.push_back(mk(1, 8'hA5, 1, 0, 8'h40, 16, 0, 0));
      for (int i = 0; i < 16; i++)
         vecs.push_back(mk(0, 0, 1, 0, (i < 15) ? 8'(8'h41 + i) : 8'hA5, 15 - i, i == 15, 0));

      foreach (vecs[i]) begin
         rx_valid = vecs[i].v; rx_data = vecs[i].d; rx_pop = vecs[i].p; clr_flags = vecs[i].c;
         if (vecs[i].p && !vecs[i].c) check($sformatf("vec%0d_head", i), rx_dout, vecs[i].exp_head);
         tick();
         idle_inputs();
         check($sformatf("vec%0d_count", i), rx_count, vecs[i].exp_cnt);
         check($sformatf("vec%0d_empty", i), rx_empty, vecs[i].exp_empty);
         check($sformatf("vec%0d_ovf", i), rx_overflow, vecs[i].exp_ovf);
      end

      // TX latency
      xm_len = 100; xm_dead = 1'b0; s0 = n_starts;
      tx_push = 1'b1; tx_din = 8'h55;
      tick();                       // edge k
      idle_inputs();
      check("t3_start_k", tx_start, 0);
      check("t3_count_k", tx_count, 1);
      tick();                       // edge k+1
      check("t3_start_k1", tx_start, 1);
      check("t3_data", tx_data, 8'h55);
      check("t3_count_k1", tx_count, 0);
      tick();                       // edge k+2
      check("t3_start_k2", tx_start, 0);
      for (int i = 0; i < 300 && !(fsm_state == ST_IDLE && tx_busy == 1'b0); i++) tick();
      check("t3_back_idle", fsm_state, ST_IDLE);
      check("t3_nstarts", n_starts - s0, 1);

      // TX burst ordering
      xm_len = 4; s0 = n_starts; sent_q.delete();
      tx_push = 1'b1;
      tx_din = 8'h31; tick();
      tx_din = 8'h32; tick();
      tx_din = 8'h33; tick();
      idle_inputs();
      for (int i = 0; i < 200 && !(n_starts - s0 == 3 && fsm_state == ST_IDLE && tx_busy == 1'b0); i++) tick();
      check("t4_nstarts", n_starts - s0, 3);
      check("t4_nbytes", sent_q.size(), 3);
      if (sent_q.size() == 3) begin
         check("t4_byte0", sent_q[0], 8'h31);
         check("t4_byte1", sent_q[1], 8'h32);
         check("t4_byte2", sent_q[2], 8'h33);
      end

      // timeout with a dead transmitter
      xm_dead = 1'b1; s0 = n_starts;
      tx_push = 1'b1; tx_din = 8'h77;
      tick();                       // edge k
      idle_inputs();
      tick();                       // edge k+1: START
      check("t5_start", tx_start, 1);
      check("t5_data", tx_data, 8'h77);
      tick();                       // edge k+2: ACK entry
      check("t5_in_ack", fsm_state, ST_ACK);
      for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
      check("t5_no_early_timeout", tx_timeout, 0);
      check("t5_still_ack", fsm_state, ST_ACK);
      tick();                       // ACK entry + ACK_TIMEOUT
      check("t5_timeout", tx_timeout, 1);
      check("t5_idle", fsm_state, ST_IDLE);
      clr_flags = 1'b1;
      tick();
      idle_inputs();
      check("t5_cleared", tx_timeout, 0);
      for (int i = 0; i < 10; i++) tick();
      check("t5_nstarts", n_starts - s0, 1);
      xm_dead = 1'b0;

      // async reset mid-DRAIN
      xm_len = 100;
      tx_push = 1'b1; tx_din = 8'h88;
      tick();
      idle_inputs();
      for (int i = 0; i < 20 && fsm_state != ST_DRAIN; i++) tick();
      check("t6_in_drain", fsm_state, ST_DRAIN);
      for (int i = 0; i < 5; i++) begin
         tx_push = 1'b1; tx_din = 8'(8'h90 + i);
         rx_valid = (i < 3); rx_data = 8'(8'hC0 + i);
         tick();
      end
      idle_inputs();
      check("t6_pre_tx_count", tx_count, 5);
      check("t6_pre_rx_count", rx_count, 3);
      #2 reset = 1'b1;
      #1;
      check("t6_tx_count", tx_count, 0);
      check("t6_rx_empty", rx_empty, 1);
      check("t6_rx_count", rx_count, 0);
      check("t6_tx_start", tx_start, 0);
      check("t6_tx_data", tx_data, 8'h00);
      check("t6_flags", {rx_overflow, tx_overflow, tx_timeout}, 0);
      check("t6_fsm", fsm_state, ST_IDLE);
      @(negedge clk_sys);
      reset = 1'b0;
      s0 = n_starts;
      for (int i = 0; i < 150; i++) tick();
      check("t6_no_start", n_starts - s0, 0);

      // randomized run against the queue model
      xm_len = 3;
      for (int n = 0; n < 1500; n++) begin
         rv = ($urandom_range(0, 99) < 45);
         rp = ($urandom_range(0, 99) < 40);
         tp = ($urandom_range(0, 99) < 35);
         cf = ($urandom_range(0, 99) < 3);
         rd = 8'($urandom);
         td = 8'($urandom);
         rx_valid = rv; rx_data = rd; rx_pop = rp; tx_push = tp; tx_din = td; clr_flags = cf;
         tsz = exp_q.size();
         tick();
         idle_inputs();

         rx_pe = rp && (rx_q.size() != 0);
         rx_ok = rv && (rx_q.size() < 16 || rx_pe);
         if (rx_pe) void'(rx_q.pop_front());
         if (rx_ok) rx_q.push_back(rd);
         m_rx_ovf = (rv && !rx_ok) || (m_rx_ovf && !cf);

         popped = (tx_start === 1'b1);
         tx_ok = tp && (tsz < 16 || popped);
         if (popped) begin
            if (tsz == 0) check("rnd_spurious_start", 1, 0);
            else check("rnd_tx_byte", tx_data, exp_q.pop_front());
         end
         if (tx_ok) exp_q.push_back(td);
         m_tx_ovf = (tp && !tx_ok) || (m_tx_ovf && !cf);

         check("rnd_rx_count", rx_count, rx_q.size());
         check("rnd_rx_empty", rx_empty, rx_q.size() == 0);
         if (rx_q.size() != 0) check("rnd_rx_dout", rx_dout, rx_q[0]);
         check("rnd_rx_ovf", rx_overflow, m_rx_ovf);
         check("rnd_tx_count", tx_count, exp_q.size());
         check("rnd_tx_full", tx_full, exp_q.size() == 16);
         check("rnd_tx_ovf", tx_overflow, m_tx_ovf);
         check("rnd_tx_timeout", tx_timeout, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
